nn_seq_ctrl: RTL



---
 rtl/nn_seq_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/nn_seq_ctrl.sv
// nn_seq_ctrl: time-multiplexed sequencer for a 4-8-1 feed-forward network.
// A single multiply-accumulate unit steps through the 32 hidden-layer products
// and then the 8 output-layer products, with a start/busy/done handshake.
// Optional feature macro: NN_SEQ_WLOAD_EN makes the 40-entry weight file
// writable while IDLE. Without it, the weights are a constant table.
module nn_seq_ctrl #(
    parameter int XW = 4,
    parameter int HW = 10,
    parameter int YW = 23
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [4*XW-1:0]   x_i,
    input  logic              wr_en_i,
    input  logic [5:0]        wr_addr_i,
    input  logic [3:0]        wr_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [YW-1:0]     y_o,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HID  = 3'd1,
        OUT  = 3'd2,
        DONE = 3'd3
    } state_t;

    // Default weights, one nibble per address; address 0 in the low nibble.
    // Top 8 nibbles are the output weights 8..1, then hidden neurons n7..n0
    // (each neuron's w3 in its high nibble).
    localparam logic [159:0] DEF_W =
        160'h87654321_7658_6587_5876_8765_3214_1243_1432_4321;

    state_t             state_reg, state_next;
    logic [4*XW-1:0]    x_reg;
    logic [YW-1:0]      acc_reg;
    logic [YW-1:0]      y_reg;
    logic [2:0]         n_reg;
    logic [1:0]         k_reg;
    logic [2:0]         j_reg;
    logic [HW-1:0]      h_reg [0:7];

    logic [5:0]         w_addr;
    logic [3:0]         w_rd;
    logic [YW-1:0]      mac_a;
    logic [YW-1:0]      prod;
    logic [YW-1:0]      acc_sum;

    // Select the MAC operands: features during HID, hidden activations during OUT.
    always_comb begin
        w_addr = {1'b0, n_reg, k_reg};
        mac_a  = YW'(x_reg[k_reg*XW +: XW]);
        if (state_reg == OUT) begin
            w_addr = 6'd32 + {3'd0, j_reg};
            mac_a  = YW'(h_reg[j_reg]);
        end
    end

`ifdef NN_SEQ_WLOAD_EN
    logic [3:0] w_reg [0:39];

    // Writable weight file; writes are only honoured while IDLE and in range.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 40; i++) begin
                w_reg[i] <= DEF_W[i*4 +: 4];
            end
        end else if (wr_en_i && (state_reg == IDLE) && (wr_addr_i < 6'd40)) begin
            w_reg[wr_addr_i] <= wr_data_i;
        end
    end

    assign w_rd = (w_addr < 6'd40) ? w_reg[w_addr] : 4'd0;
`else
    logic [7:0] w_bit;
    logic       unused_wr;

    // Constant weight table; the write port exists only for pin compatibility.
    assign w_bit     = {w_addr, 2'b00};
    assign w_rd      = DEF_W[w_bit +: 4];
    assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

    assign prod    = mac_a * YW'(w_rd);
    assign acc_sum = acc_reg + prod;

    // State register; reset wins over start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs; stray encodings fall back to IDLE.
    always_comb begin
        state_next = IDLE;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state_reg)
            IDLE: begin
                state_next = start_i ? HID : IDLE;
            end
            HID: begin
                busy_o     = 1'b1;
                state_next = ((n_reg == 3'd7) && (k_reg == 2'd3)) ? OUT : HID;
            end
            OUT: begin
                busy_o     = 1'b1;
                state_next = (j_reg == 3'd7) ? DONE : OUT;
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture inputs, accumulate products, store hidden and final results.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_reg   <= '0;
            acc_reg <= '0;
            y_reg   <= '0;
            n_reg   <= '0;
            k_reg   <= '0;
            j_reg   <= '0;
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        x_reg   <= x_i;
                        acc_reg <= '0;
                        n_reg   <= '0;
                        k_reg   <= '0;
                        j_reg   <= '0;
                    end
                end
                HID: begin
                    if (k_reg == 2'd3) begin
                        h_reg[n_reg] <= acc_sum[HW-1:0];
                        acc_reg      <= '0;
                        n_reg        <= n_reg + 3'd1;
                        k_reg        <= '0;
                    end else begin
                        acc_reg <= acc_sum;
                        k_reg   <= k_reg + 2'd1;
                    end
                end
                OUT: begin
                    j_reg <= j_reg + 3'd1;
                    if (j_reg == 3'd7) begin
                        y_reg   <= acc_sum;
                        acc_reg <= '0;
                    end else begin
                        acc_reg <= acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign y_o     = y_reg;
    assign state_o = state_reg;

endmodule
